// File: rtl/key_digit_entry.sv
// Debounced five-key editor for an 8-digit BCD number; enter commits the edit buffer
// to the number bus and locks editing until the next enter.
//
// state    | meaning
// S_EDIT   | up/down change the selected digit, left/right move the cursor, enter commits
// S_LOCKED | number is committed; only enter is honoured (reloads buffer, resumes editing)
module key_digit_entry #(
  parameter int          DEBOUNCE_CYCLES = 2_000_000,
  parameter logic [31:0] INIT_VALUE      = 32'h0000_0000
) (
  input  logic        clk100mhz,
  input  logic        clr,
  input  logic [4:0]  key_in,
  output logic [31:0] number,
  output logic [31:0] edit_buf,
  output logic [2:0]  cursor,
  output logic        editing,
  output logic        commit_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_ENTER = 4;

  typedef enum logic {S_EDIT, S_LOCKED} state_t;

  logic [4:0]    sync1, sync2, stable, press;
  logic [CW-1:0] cnt [5];

  state_t      state, state_d;
  logic [31:0] number_d, edit_buf_d;
  logic [2:0]  cursor_d;
  logic        commit_d;
  logic [4:0]  sel_lsb;
  logic [3:0]  digit, digit_inc, digit_dec;

  // Press pulse is raised on the same edge the stable level rises.
  always_ff @(posedge clk100mhz) begin
    if (clr) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          press[i]  <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (clr) begin
      state        <= S_EDIT;
      number       <= INIT_VALUE;
      edit_buf     <= INIT_VALUE;
      cursor       <= 3'd7;
      commit_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      number       <= number_d;
      edit_buf     <= edit_buf_d;
      cursor       <= cursor_d;
      commit_pulse <= commit_d;
    end
  end

  assign sel_lsb   = {cursor, 2'b00};
  assign digit     = edit_buf[sel_lsb +: 4];
  assign digit_inc = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
  assign digit_dec = (digit == 4'd0 || digit > 4'd9) ? 4'd9 : digit - 4'd1;

  // One action per cycle: enter > up > down > left > right.
  always_comb begin
    state_d    = state;
    number_d   = number;
    edit_buf_d = edit_buf;
    cursor_d   = cursor;
    commit_d   = 1'b0;
    case (state)
      S_EDIT: begin
        if (press[K_ENTER]) begin
          number_d = edit_buf;
          commit_d = 1'b1;
          state_d  = S_LOCKED;
        end else if (press[K_UP]) begin
          edit_buf_d[sel_lsb +: 4] = digit_inc;
        end else if (press[K_DOWN]) begin
          edit_buf_d[sel_lsb +: 4] = digit_dec;
        end else if (press[K_LEFT]) begin
          cursor_d = cursor + 3'd1;
        end else if (press[K_RIGHT]) begin
          cursor_d = cursor - 3'd1;
        end
      end
      S_LOCKED: begin
        if (press[K_ENTER]) begin
          edit_buf_d = number;
          cursor_d   = 3'd7;
          state_d    = S_EDIT;
        end
      end
      default: state_d = S_EDIT;
    endcase
  end

  assign editing = (state == S_EDIT);

endmodule

// File: tb/tb_key_digit_entry.sv
// Self-checking bench for key_digit_entry: directed vector table, hand-written reset
// corner case, and random key sequences checked against a digit-level model.
module tb_key_digit_entry;

  localparam int DEB = 4;

  logic        clk100mhz = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  key_in = '0;
  logic [31:0] number, edit_buf;
  logic [2:0]  cursor;
  logic        editing, commit_pulse;

  int tests = 0;
  int fails = 0;

  key_digit_entry #(.DEBOUNCE_CYCLES(DEB), .INIT_VALUE(32'h0)) dut (
    .clk100mhz(clk100mhz), .clr(clr), .key_in(key_in), .number(number),
    .edit_buf(edit_buf), .cursor(cursor), .editing(editing), .commit_pulse(commit_pulse)
  );

  always #5 clk100mhz = ~clk100mhz;

  typedef struct {
    bit          rst;
    logic [4:0]  keys;
    int          reps;
    int          hold;
    logic [31:0] eb_e;
    logic [2:0]  cur_e;
    logic        edit_e;
    logic [31:0] num_e;
    int          cp_e;
  } vec_t;

  vec_t vecs[$];

  // digit-level reference model
  int m_dig[8];
  int m_num[8];
  int m_cur;
  bit m_edit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk100mhz);
    clr = 1'b1;
    repeat (2) @(negedge clk100mhz);
    clr = 1'b0;
  endtask

  // hold keys for 'hold' sampling edges, then release long enough to settle
  task automatic press(input logic [4:0] m, input int hold, output int cp);
    cp = 0;
    key_in = m;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk100mhz);
      if (commit_pulse) cp++;
    end
    key_in = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk100mhz);
      if (commit_pulse) cp++;
    end
  endtask

  function automatic logic [31:0] pack_dig(input bit use_num);
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'(use_num ? m_num[i] : m_dig[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_dig[i] = 0;
      m_num[i] = 0;
    end
    m_cur  = 7;
    m_edit = 1'b1;
  endfunction

  function automatic int model_apply(input logic [4:0] m, input int hold);
    if (hold < DEB || m == 5'd0) return 0;
    if (m[4]) begin
      if (m_edit) begin
        for (int i = 0; i < 8; i++) m_num[i] = m_dig[i];
        m_edit = 1'b0;
        return 1;
      end
      for (int i = 0; i < 8; i++) m_dig[i] = m_num[i];
      m_cur  = 7;
      m_edit = 1'b1;
      return 0;
    end
    if (!m_edit) return 0;
    if (m[0])      m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
    else if (m[1]) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
    else if (m[2]) m_cur = (m_cur + 1) % 8;
    else           m_cur = (m_cur + 7) % 8;
    return 0;
  endfunction

  function automatic void add(input bit r, input logic [4:0] k, input int reps, input int hold,
                              input logic [31:0] eb, input logic [2:0] cur, input logic ed,
                              input logic [31:0] num, input int cp);
    vec_t v;
    v.rst = r; v.keys = k; v.reps = reps; v.hold = hold; v.eb_e = eb;
    v.cur_e = cur; v.edit_e = ed; v.num_e = num; v.cp_e = cp;
    vecs.push_back(v);
  endfunction

  initial begin
    int cp, cp_sum, exp_cp;
    logic [4:0] m;
    int h;

    // debounce boundary, wraps, digit entry, commit/lock, priority
    add(1, 5'h01, 1, 3,  32'h0000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 1, 12, 32'h1000_0000, 7, 1, 32'h0000_0000, 0);
    add(1, 5'h02, 1, 6,  32'h9000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h04, 1, 6,  32'h9000_0000, 0, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 6,  32'h9000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 1, 4,  32'h0000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 4, 4,  32'h4000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 5,  32'h4000_0000, 6, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 1, 5,  32'h4100_0000, 6, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 5,  32'h4100_0000, 5, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 2, 5,  32'h4120_0000, 5, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 5,  32'h4120_0000, 4, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 3, 5,  32'h4123_0000, 4, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 2, 5,  32'h4123_0000, 2, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 5, 5,  32'h4123_0500, 2, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 5,  32'h4123_0500, 1, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 2, 5,  32'h4123_0520, 1, 1, 32'h0000_0000, 0);
    add(0, 5'h08, 1, 5,  32'h4123_0520, 0, 1, 32'h0000_0000, 0);
    add(0, 5'h01, 1, 5,  32'h4123_0521, 0, 1, 32'h0000_0000, 0);
    add(0, 5'h10, 1, 6,  32'h4123_0521, 0, 0, 32'h4123_0521, 1);
    add(0, 5'h01, 1, 6,  32'h4123_0521, 0, 0, 32'h4123_0521, 0);
    add(0, 5'h04, 1, 6,  32'h4123_0521, 0, 0, 32'h4123_0521, 0);
    add(0, 5'h10, 1, 6,  32'h4123_0521, 7, 1, 32'h4123_0521, 0);
    add(0, 5'h02, 1, 6,  32'h3123_0521, 7, 1, 32'h4123_0521, 0);
    add(0, 5'h10, 1, 6,  32'h3123_0521, 7, 0, 32'h3123_0521, 1);
    add(1, 5'h01, 1, 6,  32'h1000_0000, 7, 1, 32'h0000_0000, 0);
    add(0, 5'h11, 1, 6,  32'h1000_0000, 7, 0, 32'h1000_0000, 1);
    add(0, 5'h10, 1, 6,  32'h1000_0000, 7, 1, 32'h1000_0000, 0);
    add(0, 5'h0C, 1, 6,  32'h1000_0000, 0, 1, 32'h1000_0000, 0);
    add(0, 5'h06, 1, 6,  32'h1000_0009, 0, 1, 32'h1000_0000, 0);

    // reset state
    do_reset();
    @(negedge clk100mhz);
    chk("rst_number", number, 32'h0);
    chk("rst_edit_buf", edit_buf, 32'h0);
    chk("rst_cursor", 32'(cursor), 32'd7);
    chk("rst_editing", 32'(editing), 32'd1);
    chk("rst_commit", 32'(commit_pulse), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cp_sum = 0;
      for (int r = 0; r < vecs[i].reps; r++) begin
        press(vecs[i].keys, vecs[i].hold, cp);
        cp_sum += cp;
      end
      chk($sformatf("vec%0d_edit_buf", i), edit_buf, vecs[i].eb_e);
      chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].cur_e));
      chk($sformatf("vec%0d_editing", i), 32'(editing), 32'(vecs[i].edit_e));
      chk($sformatf("vec%0d_number", i), number, vecs[i].num_e);
      chk($sformatf("vec%0d_commits", i), 32'(cp_sum), 32'(vecs[i].cp_e));
    end

    // right held across clr: reset values, then one press after clr release
    do_reset();
    press(5'h04, 6, cp);
    key_in = 5'h08;
    repeat (3) @(negedge clk100mhz);
    clr = 1'b1;
    repeat (2) @(negedge clk100mhz);
    chk("midrst_cursor", 32'(cursor), 32'd7);
    chk("midrst_edit_buf", edit_buf, 32'h0);
    chk("midrst_editing", 32'(editing), 32'd1);
    clr = 1'b0;
    repeat (12) @(negedge clk100mhz);
    chk("held_cursor_once", 32'(cursor), 32'd6);
    key_in = '0;
    repeat (16) @(negedge clk100mhz);
    chk("held_cursor_final", 32'(cursor), 32'd6);

    // random sequences against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 60; n++) begin
      m = 5'($urandom_range(0, 31));
      if (m[4] && $urandom_range(0, 1) == 0) m[4] = 1'b0;
      h = $urandom_range(1, 9);
      press(m, h, cp);
      exp_cp = model_apply(m, h);
      chk($sformatf("rnd%0d_edit_buf", n), edit_buf, pack_dig(1'b0));
      chk($sformatf("rnd%0d_number", n), number, pack_dig(1'b1));
      chk($sformatf("rnd%0d_cursor", n), 32'(cursor), 32'(m_cur));
      chk($sformatf("rnd%0d_editing", n), 32'(editing), 32'(m_edit));
      chk($sformatf("rnd%0d_commits", n), 32'(cp), 32'(exp_cp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
